// File: rtl/seg7_scan_display.sv
// Time-multiplexed 7-segment driver for NUM_DIGITS common-anode hex digits.
// The displayed value is double-buffered and only changes on frame boundaries.
module seg7_scan_display #(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 50000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    blank_lz,
   input  logic                    enable,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] P_TERM = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           r_pcnt;
   logic [IW-1:0]           r_idx;
   logic [4*NUM_DIGITS-1:0] r_act_val, r_pen_val;
   logic [NUM_DIGITS-1:0]   r_act_dp, r_pen_dp;
   logic                    r_act_blz, r_pen_blz, r_pend_v;
   logic [6:0]              r_seg;
   logic                    r_dp, r_fd;
   logic [NUM_DIGITS-1:0]   r_an;

   logic                    w_pterm, w_bound, w_blank, w_dpbit;
   logic [4*NUM_DIGITS-1:0] w_shift;
   logic [3:0]              w_nib;
   logic [NUM_DIGITS-1:0]   w_anode;

   function automatic logic [6:0] f_hex7(input logic [3:0] n);
      case (n)
         4'h0: f_hex7 = 7'b0000001;
         4'h1: f_hex7 = 7'b1001111;
         4'h2: f_hex7 = 7'b0010010;
         4'h3: f_hex7 = 7'b0000110;
         4'h4: f_hex7 = 7'b1001100;
         4'h5: f_hex7 = 7'b0100100;
         4'h6: f_hex7 = 7'b0100000;
         4'h7: f_hex7 = 7'b0001111;
         4'h8: f_hex7 = 7'b0000000;
         4'h9: f_hex7 = 7'b0000100;
         4'hA: f_hex7 = 7'b0001000;
         4'hB: f_hex7 = 7'b1100000;
         4'hC: f_hex7 = 7'b0110001;
         4'hD: f_hex7 = 7'b1000010;
         4'hE: f_hex7 = 7'b0110000;
         default: f_hex7 = 7'b0111000;
      endcase
   endfunction

   assign w_pterm = (r_pcnt == P_TERM);
   assign w_bound = w_pterm && (r_idx == I_LAST);

   // Shifting the current digit down to bit 0 also tells us whether it and
   // everything above it are zero, which is the leading-zero condition.
   assign w_shift = r_act_val >> {r_idx, 2'b00};
   assign w_nib   = w_shift[3:0];
   assign w_blank = r_act_blz && (r_idx != '0) && (w_shift == '0);
   assign w_dpbit = r_act_dp[r_idx];
   assign w_anode = ~(NUM_DIGITS'(1) << r_idx);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pcnt <= '0;
         r_idx  <= '0;
      end else if (w_pterm) begin
         r_pcnt <= '0;
         r_idx  <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

   // A load landing on the boundary bypasses the pending buffer entirely.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_act_val <= '0;
         r_act_dp  <= '0;
         r_act_blz <= 1'b0;
         r_pen_val <= '0;
         r_pen_dp  <= '0;
         r_pen_blz <= 1'b0;
         r_pend_v  <= 1'b0;
      end else if (w_bound && load) begin
         r_act_val <= value;
         r_act_dp  <= dp_mask;
         r_act_blz <= blank_lz;
         r_pend_v  <= 1'b0;
      end else if (w_bound && r_pend_v) begin
         r_act_val <= r_pen_val;
         r_act_dp  <= r_pen_dp;
         r_act_blz <= r_pen_blz;
         r_pend_v  <= 1'b0;
      end else if (load) begin
         r_pen_val <= value;
         r_pen_dp  <= dp_mask;
         r_pen_blz <= blank_lz;
         r_pend_v  <= 1'b1;
      end
   end

   // Anodes stay off in the first cycle of every slot to hide segment changes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg <= 7'b1111111;
         r_dp  <= 1'b1;
         r_an  <= '1;
         r_fd  <= 1'b0;
      end else begin
         r_fd <= w_bound;
         if (!enable) begin
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
            r_an  <= '1;
         end else begin
            r_seg <= w_blank ? 7'b1111111 : f_hex7(w_nib);
            r_dp  <= ~w_dpbit;
            r_an  <= ((r_pcnt == '0) || (w_blank && !w_dpbit)) ? '1 : w_anode;
         end
      end
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign an         = r_an;
   assign frame_done = r_fd;

endmodule
